mul_operand_sequencer: RTL and testbench
========================================

Name: mul_operand_sequencer

Overview:
Upstream feeder for the 16x16 signed variable-latency multiplier. It buffers operand pairs in a small FIFO and presents one pair at a time on stable mul_a/mul_b. It clears the multiplier, asserts mul_loaded, waits for mul_completed, then returns the 32-bit product through a valid/ready output port. This serialises back-to-back multiplications through the single multiplier instance.

Parameters:
DEPTH, 4, operand FIFO entries; power of two, minimum 2.
TIMEOUT, 64, maximum cycles allowed in RUN before the operation is aborted.

Ports:
clk  input  1  clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand pair offered.
in_ready  output  1  FIFO can accept; equals !full.
in_a  input  16  signed multiplicand (m).
in_b  input  16  signed multiplier (q).
mul_a  output  16  operand a to multiplier; registered; stable from CLEAR through DONE.
mul_b  output  16  operand b to multiplier; registered; stable from CLEAR through DONE.
mul_clear  output  1  one-cycle synchronous clear pulse to the multiplier's internal state.
mul_loaded  output  1  multiplier "loaded" input.
mul_c  input  32  multiplier product.
mul_completed  input  1  multiplier done flag; level, held until clear.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
out_c  output  32  signed product.
out_err  output  1  qualifies out_c; 1 = timeout, out_c = 0.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied, state=IDLE. mul_a, mul_b, out_c = 0. mul_clear, mul_loaded, out_valid, out_err, busy = 0. in_ready=1 on the cycle after reset. Reset mid-operation abandons the pair and discards the FIFO contents.
- FIFO push: on in_valid && in_ready. Pop: only in IDLE when non-empty. Push and pop in the same cycle are both allowed; the count is unchanged.
- A push into an empty FIFO is seen by IDLE on the following cycle (no bypass).
- Full: in_ready=0; in_valid is ignored and the data is not stored.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a log2(DEPTH)+1 bit count.
- IDLE: if non-empty, pop head into mul_a/mul_b, set mul_clear=1, go to CLEAR. Otherwise stay.
- CLEAR (1 cycle): mul_clear=0, mul_loaded=1, timeout counter=0, go to RUN.
- RUN: mul_loaded held at 1; the counter increments each cycle.
  - If mul_completed=1: capture out_c<=mul_c, out_err<=0, out_valid<=1, mul_loaded<=0, go to DONE.
  - Else if counter==TIMEOUT-1: out_c<=0, out_err<=1, out_valid<=1, mul_loaded<=0, go to DONE.
  - If both conditions hold in the same cycle, completion wins.
- DONE: out_valid held with out_c/out_err stable until out_ready=1. On acceptance, out_valid<=0 and go to IDLE. No pop happens on that same cycle.
- mul_completed is ignored outside RUN. A stale high completed flag is removed by the mul_clear pulse before mul_loaded rises.
- Minimum issue-to-issue spacing is 4 cycles plus multiplier latency. Only one operation is in flight.
- Product width: full 32-bit signed; no truncation or saturation.

Optional Feature:
LATENCY_COUNT_EN
- Defined: adds output lat_cycles [7:0] and output total_ops [15:0].
  - lat_cycles is loaded with the RUN cycle count when entering DONE, and holds until the next DONE.
  - total_ops increments once per accepted result, including errors, and wraps at 65535->0.
  - Both reset to 0.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Reset then push (3,5), out_ready=1: mul_clear pulses once, then mul_loaded=1 until completed. Result: out_c=15, out_err=0, busy returns to 0.
- Push (-2,7), (0x7FFF,0x7FFF), (-32768,-32768) back-to-back, out_ready=1: results appear in order as -14, 0x3FFF0001, 0x40000000. mul_a/mul_b stay stable throughout each RUN.
- DEPTH=4, out_ready=0, offer 6 pairs: 5 are accepted (4 in FIFO, 1 in flight) and in_ready=0 after that. Raising out_ready drains all 5 with correct products; the 6th is accepted once in_ready=1.
- Stub multiplier holding mul_completed=0 for 64 cycles: out_valid=1, out_err=1, out_c=0 after TIMEOUT cycles in RUN. The next queued pair then completes normally.
- rst_n=0 during RUN with 2 pairs queued: the next cycle shows all outputs 0, FIFO empty, in_ready=1. No stale result is emitted afterwards.
- With LATENCY_COUNT_EN defined, stub with 5-cycle latency, 3 ops: lat_cycles=5 after each op, total_ops=3.

Source files
------------

// File: rtl/mul_operand_sequencer.sv
// Operand FIFO and sequencer feeding one 16x16 signed variable-latency multiplier.
// Optional feature macro: LATENCY_COUNT_EN adds lat_cycles / total_ops statistics outputs.
module mul_operand_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_clear,
  output logic        mul_loaded,
  input  logic [31:0] mul_c,
  input  logic        mul_completed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic        out_err,
  output logic        busy
`ifdef LATENCY_COUNT_EN
  ,
  output logic [7:0]  lat_cycles,
  output logic [15:0] total_ops
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t        state;
  logic [15:0]   mem_a [DEPTH];
  logic [15:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] tmo_cnt;
  logic          push;
  logic          pop;

  assign in_ready = (count != FULL_COUNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tmo_cnt    <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_clear  <= 1'b0;
      mul_loaded <= 1'b0;
      out_valid  <= 1'b0;
      out_c      <= '0;
      out_err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (pop) begin
            mul_a     <= mem_a[rd_ptr];
            mul_b     <= mem_b[rd_ptr];
            mul_clear <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          // the clear pulse has wiped any stale completed flag before loaded rises
          mul_clear  <= 1'b0;
          mul_loaded <= 1'b1;
          tmo_cnt    <= '0;
          state      <= RUN;
        end
        RUN: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (mul_completed) begin
            out_c      <= mul_c;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            mul_loaded <= 1'b0;
            state      <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            out_c      <= '0;
            out_err    <= 1'b1;
            out_valid  <= 1'b1;
            mul_loaded <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef LATENCY_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_cycles <= '0;
      total_ops  <= '0;
    end else begin
      // RUN length includes the cycle that leaves RUN
      if (state == RUN && (mul_completed || tmo_cnt == TMO_LAST))
        lat_cycles <= 8'(tmo_cnt + 1'b1);
      if (state == DONE && out_ready)
        total_ops <= total_ops + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Randomised self-checking bench for mul_operand_sequencer with a stub variable-latency multiplier.
module tb_mul_operand_sequencer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_ready, mul_clear, mul_loaded, out_valid, out_err, busy, mul_completed;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_c, out_c;
`ifdef LATENCY_COUNT_EN
  logic [7:0]  lat_cycles;
  logic [15:0] total_ops;
`endif

  always #5 clk = ~clk;

  mul_operand_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_clear(mul_clear), .mul_loaded(mul_loaded), .mul_c(mul_c),
    .mul_completed(mul_completed), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_err(out_err), .busy(busy)
`ifdef LATENCY_COUNT_EN
    , .lat_cycles(lat_cycles), .total_ops(total_ops)
`endif
  );

  // Stub multiplier: completed rises in the stub_lat-th cycle with loaded high, held until clear.
  int                 stub_k = 0;
  int                 stub_lat = 1;
  int                 next_lat = 1;
  logic [31:0]        junk = '0;
  logic signed [31:0] stub_prod;
  always @(posedge clk) begin
    junk <= $urandom;
    if (mul_clear) begin
      stub_k   <= 0;
      stub_lat <= next_lat;
    end else if (mul_loaded) begin
      stub_k <= stub_k + 1;
    end
  end
  assign mul_completed = (stub_k >= stub_lat) || (mul_loaded && stub_k == stub_lat - 1);
  assign stub_prod     = $signed(mul_a) * $signed(mul_b);
  assign mul_c         = mul_completed ? stub_prod : junk;

  // Transaction-level reference model
  typedef struct {logic [15:0] a; logic [15:0] b;} pair_t;
  pair_t       q[$];
  pair_t       cur;
  bit          inflight = 0;
  bit          fresh = 1;
  bit          cur_err = 0;
  int          age = 0;
  int          run_len = 0;
  int          exp_lat = 0;
  int          exp_tot = 0;
  int          force_lat = 0;
  int          tests = 0;
  int          fails = 0;
  logic [32:0] results[$];

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 1000;
    if (r == 1) return TIMEOUT;
    if (r == 2) return TIMEOUT + 1;
    return $urandom_range(1, 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_result(input string name, input int idx, input logic [32:0] exp);
    tests++;
    if (idx >= results.size()) begin
      fails++;
      $display("FAIL %s: no result #%0d (only %0d seen) expected %0h", name, idx, results.size(), exp);
    end else if (results[idx] !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, results[idx], exp);
    end
  endtask

  task automatic check_outputs();
    bit valid_exp;
    valid_exp = inflight && age >= run_len + 2;
    chk("busy", busy, inflight);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("mul_clear", mul_clear, inflight && age == 1);
    chk("mul_loaded", mul_loaded, inflight && age >= 2 && age <= run_len + 1);
    chk("out_valid", out_valid, valid_exp);
    if (inflight) begin
      chk("mul_a", mul_a, cur.a);
      chk("mul_b", mul_b, cur.b);
    end
    if (fresh) begin
      chk("reset_mul_a", mul_a, 0);
      chk("reset_mul_b", mul_b, 0);
      chk("reset_out_c", out_c, 0);
      chk("reset_out_err", out_err, 0);
    end
    if (valid_exp) begin
      chk("out_c", out_c, cur_err ? 32'd0 : prod(cur.a, cur.b));
      chk("out_err", out_err, cur_err);
    end
`ifdef LATENCY_COUNT_EN
    chk("lat_cycles", lat_cycles, exp_lat);
    chk("total_ops", total_ops, exp_tot);
`endif
  endtask

  // Advance the model by one clock edge using the inputs that edge will sample.
  task automatic model_edge();
    bit push;
    int lat;
    if (!rst_n) begin
      q.delete();
      inflight = 0;
      age      = 0;
      fresh    = 1;
      exp_lat  = 0;
      exp_tot  = 0;
      return;
    end
    push = in_valid && (q.size() < DEPTH);
    if (inflight) begin
      if (age >= run_len + 2 && out_ready) begin
        inflight = 0;
        exp_tot  = (exp_tot + 1) % 65536;
      end else begin
        age++;
        if (age == run_len + 2) exp_lat = run_len;
      end
    end else if (q.size() != 0) begin
      cur      = q.pop_front();
      inflight = 1;
      age      = 1;
      fresh    = 0;
      lat      = (force_lat != 0) ? force_lat : pick_lat();
      next_lat = lat;
      run_len  = (lat > TIMEOUT) ? TIMEOUT : lat;
      cur_err  = (lat > TIMEOUT);
    end
    if (push) q.push_back(pair_t'{in_a, in_b});
  endtask

  task automatic step(input logic rv, input logic iv, input logic [15:0] a,
                      input logic [15:0] b, input logic ordy);
    @(negedge clk);
    check_outputs();
    rst_n     = rv;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    if (rv && out_valid && ordy) results.push_back({out_err, out_c});
    model_edge();
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'd0, 16'd0, ordy);
  endtask

  function automatic logic [15:0] rand_op();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) step(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    step(1'b1, 1'b0, 16'd0, 16'd0, 1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    // single op 3*5
    force_lat = 4;
    step(1'b1, 1'b1, 16'd3, 16'd5, 1'b1);
    idle(15, 1'b1);
    chk_result("t1_3x5", 0, {1'b0, 32'd15});
    chk("t1_busy_end", busy, 0);
`ifdef LATENCY_COUNT_EN
    chk("t1_lat_cycles", lat_cycles, 4);
    chk("t1_total_ops", total_ops, 1);
`endif

    // back-to-back corner products
    force_lat = 3;
    step(1'b1, 1'b1, 16'hFFFE, 16'd7, 1'b1);
    step(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1);
    step(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b1);
    idle(40, 1'b1);
    chk_result("t2_neg2x7", 1, {1'b0, 32'hFFFF_FFF2});
    chk_result("t2_maxpos", 2, {1'b0, 32'h3FFF_0001});
    chk_result("t2_maxneg", 3, {1'b0, 32'h4000_0000});

    // fill: 5 accepted (4 queued, 1 in flight), 6th refused
    force_lat = 2;
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 16'(10 + 2 * i), 16'(11 + 2 * i), 1'b0);
    idle(10, 1'b0);
    chk("t3_full_in_ready", in_ready, 0);
    idle(45, 1'b1);
    chk("t3_drained_count", results.size(), 9);
    chk_result("t3_first", 4, {1'b0, 32'd110});
    chk_result("t3_fifth", 8, {1'b0, 32'd342});
    step(1'b1, 1'b1, 16'd20, 16'd21, 1'b1);
    idle(12, 1'b1);
    chk_result("t3_sixth", 9, {1'b0, 32'd420});

    // timeout, then a normal op behind it
    force_lat = 1000;
    step(1'b1, 1'b1, 16'd9, 16'd9, 1'b1);
    idle(1, 1'b1);
    force_lat = 2;
    step(1'b1, 1'b1, 16'd2, 16'd3, 1'b1);
    idle(90, 1'b1);
    chk_result("t4_timeout", 10, {1'b1, 32'd0});
    chk_result("t4_after", 11, {1'b0, 32'd6});

    // completion on the last allowed cycle wins; one cycle later times out
    force_lat = TIMEOUT;
    step(1'b1, 1'b1, 16'd4, 16'd4, 1'b1);
    idle(1, 1'b1);
    force_lat = TIMEOUT + 1;
    step(1'b1, 1'b1, 16'd5, 16'd5, 1'b1);
    idle(160, 1'b1);
    chk_result("t5_edge_complete", 12, {1'b0, 32'd16});
    chk_result("t5_edge_timeout", 13, {1'b1, 32'd0});

    // reset during RUN with two pairs queued
    force_lat = 1000;
    step(1'b1, 1'b1, 16'd1, 16'd1, 1'b1);
    step(1'b1, 1'b1, 16'd2, 16'd2, 1'b1);
    step(1'b1, 1'b1, 16'd3, 16'd3, 1'b1);
    idle(5, 1'b1);
    chk("t6_in_run", mul_loaded, 1);
    step(1'b0, 1'b0, 16'd0, 16'd0, 1'b1);
    step(1'b1, 1'b0, 16'd0, 16'd0, 1'b1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_loaded", mul_loaded, 0);
    chk("t6_rst_out_valid", out_valid, 0);
    idle(80, 1'b1);
    chk("t6_no_stale", results.size(), 14);

    // randomised traffic
    force_lat = 0;
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 599) != 0), ($urandom_range(0, 2) != 0),
           rand_op(), rand_op(), ($urandom_range(0, 3) != 0));
    end
    idle(200, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
